// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter in front of a single data memory.
// Port 0 is the load-store unit, port 1 the DMA/debug port. One access is in
// flight at a time. Simultaneous requests alternate through a one-bit
// "last served" pointer. A wait counter aborts accesses that the memory never
// completes.
module dmem_arbiter #(
    parameter int TIMEOUT = 15,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              wr0,
    input  logic              wr1,
    input  logic [3:0]        mask0,
    input  logic [3:0]        mask1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [31:0]       wdata0,
    input  logic [31:0]       wdata1,
    output logic              valid0,
    output logic              valid1,
    output logic              err0,
    output logic              err1,
    output logic [31:0]       rdata0,
    output logic [31:0]       rdata1,
    output logic              busy,
    output logic              cs,
    output logic              wr,
    output logic [3:0]        mask,
    output logic [ADDR_W-1:0] addr,
    output logic [31:0]       data_wr,
    input  logic [31:0]       data_rd,
    input  logic              valid_DM
);

    // Enough bits to hold TIMEOUT itself; never narrower than one bit.
    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_t;

    state_t           state_r;
    logic             last_r;     // port served most recently; 1 after reset so port 0 wins first tie
    logic [CNT_W-1:0] cnt_r;      // BUSY cycles spent without a memory completion
    logic             at_limit_s;
    logic             done_s;     // access ends this cycle (completion or timeout)
    logic             timeout_s;  // access ends this cycle by timeout

    assign at_limit_s = (cnt_r == CNT_MAX);
    assign done_s     = valid_DM | at_limit_s;
    assign timeout_s  = at_limit_s & ~valid_DM;

    // Arbitration, access sequencing and wait counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            last_r  <= 1'b1;
            cnt_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    cnt_r <= '0;
                    if (req0 && (!req1 || last_r)) begin
                        state_r <= BUSY0;
                        last_r  <= 1'b0;
                    end else if (req1) begin
                        state_r <= BUSY1;
                        last_r  <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY0, BUSY1: begin
                    if (done_s) begin
                        state_r <= IDLE;
                        cnt_r   <= '0;
                    end else begin
                        cnt_r   <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

    // Memory request mux and per-port completion signals; all forced low while rst is high.
    always_comb begin
        cs      = 1'b0;
        wr      = 1'b0;
        mask    = 4'h0;
        addr    = '0;
        data_wr = 32'h0000_0000;
        valid0  = 1'b0;
        valid1  = 1'b0;
        err0    = 1'b0;
        err1    = 1'b0;
        rdata0  = 32'h0000_0000;
        rdata1  = 32'h0000_0000;
        busy    = 1'b0;
        if (!rst) begin
            case (state_r)
                BUSY0: begin
                    busy    = 1'b1;
                    cs      = 1'b1;
                    wr      = wr0;
                    mask    = mask0;
                    addr    = addr0;
                    data_wr = wdata0;
                    valid0  = done_s;
                    err0    = timeout_s;
                    rdata0  = valid_DM ? data_rd : 32'h0000_0000;
                end
                BUSY1: begin
                    busy    = 1'b1;
                    cs      = 1'b1;
                    wr      = wr1;
                    mask    = mask1;
                    addr    = addr1;
                    data_wr = wdata1;
                    valid1  = done_s;
                    err1    = timeout_s;
                    rdata1  = valid_DM ? data_rd : 32'h0000_0000;
                end
                default: begin
                    busy    = 1'b0;
                end
            endcase
        end else begin
            busy = 1'b0;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios followed by a randomized run
// compared against a transaction-level reference model.
module tb_dmem_arbiter;

    localparam int TIMEOUT = 15;
    localparam int ADDR_W  = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              req0, req1, wr0, wr1;
    logic [3:0]        mask0, mask1, mask;
    logic [ADDR_W-1:0] addr0, addr1, addr;
    logic [31:0]       wdata0, wdata1, data_wr, data_rd, rdata0, rdata1;
    logic              valid0, valid1, err0, err1, busy, cs, wr, valid_DM;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: who owns the memory (-1 none), cycles waited, preferred port on a tie.
    int m_owner, m_wait, m_pref;
    logic              e_cs, e_wr, e_busy, e_v0, e_v1, e_e0, e_e1;
    logic [3:0]        e_mask;
    logic [ADDR_W-1:0] e_addr;
    logic [31:0]       e_dwr, e_rd0, e_rd1;
    logic              e_done;

    dmem_arbiter #(.TIMEOUT(TIMEOUT), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
        .mask0(mask0), .mask1(mask1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .valid0(valid0), .valid1(valid1), .err0(err0), .err1(err1),
        .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
        .cs(cs), .wr(wr), .mask(mask), .addr(addr), .data_wr(data_wr),
        .data_rd(data_rd), .valid_DM(valid_DM)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs for the current cycle from the access rules.
    task automatic model_predict();
        e_cs = 1'b0; e_wr = 1'b0; e_mask = 4'h0; e_addr = '0; e_dwr = 32'h0;
        e_v0 = 1'b0; e_v1 = 1'b0; e_e0 = 1'b0; e_e1 = 1'b0;
        e_rd0 = 32'h0; e_rd1 = 32'h0; e_busy = 1'b0;
        e_done = valid_DM || (m_wait == TIMEOUT);
        if (!rst && m_owner >= 0) begin
            e_busy = 1'b1;
            e_cs   = 1'b1;
            e_wr   = (m_owner == 0) ? wr0 : wr1;
            e_mask = (m_owner == 0) ? mask0 : mask1;
            e_addr = (m_owner == 0) ? addr0 : addr1;
            e_dwr  = (m_owner == 0) ? wdata0 : wdata1;
            if (m_owner == 0) begin
                e_v0 = e_done; e_e0 = e_done && !valid_DM; e_rd0 = valid_DM ? data_rd : 32'h0;
            end else begin
                e_v1 = e_done; e_e1 = e_done && !valid_DM; e_rd1 = valid_DM ? data_rd : 32'h0;
            end
        end
    endtask

    // Advance the model across the coming clock edge.
    task automatic model_advance();
        if (rst) begin
            m_owner = -1; m_wait = 0; m_pref = 0;
        end else if (m_owner < 0) begin
            if (req0 && req1) m_owner = m_pref;
            else if (req0)    m_owner = 0;
            else if (req1)    m_owner = 1;
            if (m_owner >= 0) m_pref = 1 - m_owner;
            m_wait = 0;
        end else if (valid_DM || m_wait == TIMEOUT) begin
            m_owner = -1; m_wait = 0;
        end else begin
            m_wait = m_wait + 1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req0 = 1'b1; req1 = 1'b1; valid_DM = 1'b1; data_rd = 32'hFFFF_FFFF;
        wr0 = 1'b1; wr1 = 1'b1; mask0 = 4'hF; mask1 = 4'hF;
        addr0 = 32'h1234; addr1 = 32'h5678; wdata0 = 32'h1111_1111; wdata1 = 32'h2222_2222;
        tick(); tick();
        #4;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if ({cs, wr, mask} !== 6'b0) begin n_err++; $display("FAIL reset_mem_ctl: got cs=%b wr=%b mask=%h want 0", cs, wr, mask); end
        n_vec++; if ({addr, data_wr} !== 64'h0) begin n_err++; $display("FAIL reset_mem_data: got addr=%h data_wr=%h want 0", addr, data_wr); end
        n_vec++; if ({valid0, valid1, err0, err1} !== 4'b0) begin n_err++; $display("FAIL reset_valid_err: got %b want 0000", {valid0, valid1, err0, err1}); end
        n_vec++; if ({rdata0, rdata1} !== 64'h0) begin n_err++; $display("FAIL reset_rdata: got %h %h want 0", rdata0, rdata1); end
        tick();
        req0 = 1'b0; req1 = 1'b0; valid_DM = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_load();
        req0 = 1'b1; wr0 = 1'b0; addr0 = 32'h10; mask0 = 4'hF;
        #4;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL load_idle_busy: got %b want 0", busy); end
        tick();
        for (int i = 1; i <= 3; i++) begin
            valid_DM = (i == 3); data_rd = 32'hDEAD_BEEF;
            #4;
            if (i == 1) begin
                n_vec++; if ({cs, wr} !== 2'b10 || addr !== 32'h10) begin n_err++; $display("FAIL load_req: got cs=%b wr=%b addr=%h want cs=1 wr=0 addr=10", cs, wr, addr); end
            end
            if (i < 3) begin
                n_vec++; if (valid0 !== 1'b0) begin n_err++; $display("FAIL load_early_valid: cycle %0d got %b want 0", i, valid0); end
            end else begin
                n_vec++; if (valid0 !== 1'b1 || rdata0 !== 32'hDEAD_BEEF || err0 !== 1'b0) begin n_err++; $display("FAIL load_done: got valid0=%b err0=%b rdata0=%h want 1 0 deadbeef", valid0, err0, rdata0); end
            end
            tick();
        end
        req0 = 1'b0; valid_DM = 1'b0;
        #4;
        n_vec++; if (cs !== 1'b0) begin n_err++; $display("FAIL load_after_cs: got %b want 0", cs); end
        tick();
    endtask

    task automatic test_arbitration();
        int order[$];
        rst = 1'b1; req0 = 1'b1; req1 = 1'b1; wr0 = 1'b0; wr1 = 1'b0; valid_DM = 1'b0;
        tick(); tick();
        rst = 1'b0;
        for (int k = 0; k < 40 && order.size() < 4; k++) begin
            valid_DM = busy;
            data_rd  = $urandom;
            #4;
            if (valid0) order.push_back(0);
            if (valid1) order.push_back(1);
            tick();
        end
        req0 = 1'b0; req1 = 1'b0; valid_DM = 1'b0;
        n_vec++;
        if (order.size() != 4) begin
            n_err++; $display("FAIL arb_count: got %0d grants want 4", order.size());
        end else if (order[0] != 0 || order[1] != 1 || order[2] != 0 || order[3] != 1) begin
            n_err++; $display("FAIL arb_order: got %0d %0d %0d %0d want 0 1 0 1", order[0], order[1], order[2], order[3]);
        end
        tick();
    endtask

    task automatic test_store();
        int pulses = 0;
        req1 = 1'b1; wr1 = 1'b1; mask1 = 4'hF; wdata1 = 32'h1234_5678; addr1 = 32'h40;
        req0 = 1'b0; wr0 = 1'b0; mask0 = 4'h3; wdata0 = 32'hCAFE_F00D; addr0 = 32'h99;
        tick();
        for (int i = 1; i <= 4; i++) begin
            valid_DM = (i == 2);
            if (i == 3) req1 = 1'b0;
            #4;
            if (valid1) pulses++;
            if (i <= 2) begin
                n_vec++; if ({cs, wr} !== 2'b11 || data_wr !== 32'h1234_5678 || mask !== 4'hF || addr !== 32'h40) begin
                    n_err++; $display("FAIL store_req: cycle %0d got cs=%b wr=%b data_wr=%h mask=%h addr=%h", i, cs, wr, data_wr, mask, addr);
                end
            end
            tick();
        end
        valid_DM = 1'b0;
        n_vec++; if (pulses != 1) begin n_err++; $display("FAIL store_pulses: got %0d want 1", pulses); end
    endtask

    task automatic test_timeout();
        req0 = 1'b1; wr0 = 1'b0; addr0 = 32'h80; valid_DM = 1'b0; data_rd = 32'hA5A5_A5A5;
        tick();
        for (int i = 1; i <= TIMEOUT + 1; i++) begin
            #4;
            if (i <= TIMEOUT) begin
                n_vec++; if (valid0 !== 1'b0 || err0 !== 1'b0) begin n_err++; $display("FAIL timeout_early: cycle %0d got valid0=%b err0=%b want 0 0", i, valid0, err0); end
            end else begin
                n_vec++; if (valid0 !== 1'b1 || err0 !== 1'b1 || rdata0 !== 32'h0) begin n_err++; $display("FAIL timeout_abort: got valid0=%b err0=%b rdata0=%h want 1 1 0", valid0, err0, rdata0); end
            end
            tick();
        end
        req0 = 1'b0;
        #4;
        n_vec++; if (busy !== 1'b0 || valid0 !== 1'b0) begin n_err++; $display("FAIL timeout_idle: got busy=%b valid0=%b want 0 0", busy, valid0); end
        tick();
    endtask

    task automatic test_rst_mid();
        req1 = 1'b1; wr1 = 1'b0; addr1 = 32'h100; req0 = 1'b0; valid_DM = 1'b0;
        tick();
        req0 = 1'b1; addr0 = 32'h200; wr0 = 1'b0;
        #4;
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL rstmid_busy1: got %b want 1", busy); end
        tick();
        rst = 1'b1; valid_DM = 1'b1;
        #4;
        n_vec++; if (valid1 !== 1'b0 || err1 !== 1'b0 || cs !== 1'b0) begin n_err++; $display("FAIL rstmid_during: got valid1=%b err1=%b cs=%b want 0", valid1, err1, cs); end
        tick();
        rst = 1'b0; req1 = 1'b0; valid_DM = 1'b0;
        #4;
        n_vec++; if (busy !== 1'b0 || valid1 !== 1'b0) begin n_err++; $display("FAIL rstmid_after: got busy=%b valid1=%b want 0 0", busy, valid1); end
        tick();
        valid_DM = 1'b1; data_rd = 32'h0BAD_F00D;
        #4;
        n_vec++; if (cs !== 1'b1 || addr !== 32'h200 || valid0 !== 1'b1 || rdata0 !== 32'h0BAD_F00D) begin
            n_err++; $display("FAIL rstmid_regrant: got cs=%b addr=%h valid0=%b rdata0=%h want 1 200 1 0badf00d", cs, addr, valid0, rdata0);
        end
        tick();
        req0 = 1'b0; valid_DM = 1'b0;
        tick();
    endtask

    task automatic test_spurious();
        req0 = 1'b0; req1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            valid_DM = 1'b1; data_rd = $urandom;
            #4;
            n_vec++; if (valid0 !== 1'b0 || valid1 !== 1'b0 || cs !== 1'b0) begin n_err++; $display("FAIL spurious: got valid0=%b valid1=%b cs=%b want 0 0 0", valid0, valid1, cs); end
            tick();
        end
        valid_DM = 1'b0;
    endtask

    task automatic test_random();
        logic act0 = 1'b0, act1 = 1'b0, seen0 = 1'b0, seen1 = 1'b0;
        for (int c = 0; c < 600; c++) begin
            rst = (c < 2) || ($urandom_range(99) == 0);
            if (act0 && seen0) act0 = 1'b0;
            else if (!act0 && $urandom_range(2) == 0) begin
                act0 = 1'b1; wr0 = $urandom; mask0 = $urandom; addr0 = $urandom; wdata0 = $urandom;
            end
            if (!act0) begin wr0 = $urandom; mask0 = $urandom; addr0 = $urandom; wdata0 = $urandom; end
            if (act1 && seen1) act1 = 1'b0;
            else if (!act1 && $urandom_range(2) == 0) begin
                act1 = 1'b1; wr1 = $urandom; mask1 = $urandom; addr1 = $urandom; wdata1 = $urandom;
            end
            if (!act1) begin wr1 = $urandom; mask1 = $urandom; addr1 = $urandom; wdata1 = $urandom; end
            req0 = act0; req1 = act1;
            valid_DM = ($urandom_range(99) < 30);
            data_rd = $urandom;
            model_predict();
            #4;
            n_vec++;
            if (busy !== e_busy || cs !== e_cs || wr !== e_wr || mask !== e_mask) begin
                n_err++; $display("FAIL rand_ctl: cyc %0d got busy=%b cs=%b wr=%b mask=%h want %b %b %b %h", c, busy, cs, wr, mask, e_busy, e_cs, e_wr, e_mask);
            end
            if (e_busy || rst) begin
                n_vec++;
                if (addr !== e_addr || data_wr !== e_dwr) begin
                    n_err++; $display("FAIL rand_data: cyc %0d got addr=%h data_wr=%h want %h %h", c, addr, data_wr, e_addr, e_dwr);
                end
            end
            n_vec++;
            if (valid0 !== e_v0 || valid1 !== e_v1 || err0 !== e_e0 || err1 !== e_e1) begin
                n_err++; $display("FAIL rand_valid: cyc %0d got v=%b%b e=%b%b want %b%b %b%b", c, valid0, valid1, err0, err1, e_v0, e_v1, e_e0, e_e1);
            end
            if (e_v0 || m_owner != 0 || rst) begin
                n_vec++; if (rdata0 !== e_rd0) begin n_err++; $display("FAIL rand_rdata0: cyc %0d got %h want %h", c, rdata0, e_rd0); end
            end
            if (e_v1 || m_owner != 1 || rst) begin
                n_vec++; if (rdata1 !== e_rd1) begin n_err++; $display("FAIL rand_rdata1: cyc %0d got %h want %h", c, rdata1, e_rd1); end
            end
            seen0 = e_v0; seen1 = e_v1;
            model_advance();
            tick();
        end
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0; valid_DM = 1'b0;
        tick();
    endtask

    // Scenario sequence.
    initial begin
        m_owner = -1; m_wait = 0; m_pref = 0;
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; valid_DM = 1'b0; data_rd = 32'h0;
        wr0 = 1'b0; wr1 = 1'b0; mask0 = 4'h0; mask1 = 4'h0;
        addr0 = '0; addr1 = '0; wdata0 = 32'h0; wdata1 = 32'h0;
        #1;
        test_reset();
        test_load();
        test_arbitration();
        test_store();
        test_timeout();
        test_rst_mid();
        test_spurious();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
